// File: rtl/hwpf_issuer.sv
// hwpf_issuer: consumer end of the hardware-prefetcher address stack.
// Pops a trigger address and requests the NUM_LINES cache lines that follow it,
// with one request in flight at a time and a response timeout.
// Optional feature macro: HWPF_PAGE_CROSS_EN. When defined, requests continue
// into the next page. When undefined (the default), a trigger stops at the
// first line that falls in a different page from the trigger line.
module hwpf_issuer #(
  parameter int ADDR_W         = 40,
  parameter int LINE_BYTES     = 64,
  parameter int NUM_LINES      = 2,
  parameter int PAGE_BYTES     = 4096,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stack_valid_i,
  input  logic [ADDR_W-1:0] stack_req_i,
  output logic              stack_pop_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              rsp_valid_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CntW   = $clog2(NUM_LINES + 1);

  localparam logic [ADDR_W-1:0] LineStep  = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] LineMask  = ~(ADDR_W'(LINE_BYTES - 1));
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0]   CntLast   = CntW'(NUM_LINES);
  localparam logic [CntW-1:0]   CntFirst  = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StIssue,
    StWait
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] nextAddr_q, nextAddr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic [ADDR_W-1:0] alignedReq;
  logic              popFire;
  logic              pageCross;
  logic              timerExpired;

  // The trigger is always tracked at cache-line granularity.
  assign alignedReq   = stack_req_i & LineMask;
  assign timerExpired = (timer_q == TimerLast);

  // A pop happens only from IDLE, and never in a flush or reset cycle.
  assign popFire = (state_q == StIdle) & stack_valid_i & ~flush_i & ~rst_i;

`ifdef HWPF_PAGE_CROSS_EN
  // Page boundaries are not a stopping point, so no trigger line is kept.
  assign pageCross = 1'b0;
`else
  logic [ADDR_W-1:0] base_q, base_d;

  // The trigger line is kept only to tell which page the trigger lives in.
  assign pageCross = (nextAddr_q[ADDR_W-1:$clog2(PAGE_BYTES)] !=
                      base_q[ADDR_W-1:$clog2(PAGE_BYTES)]);

  // Capture the aligned trigger line whenever a new trigger is popped.
  always_comb begin
    base_d = base_q;
    if (popFire) begin
      base_d = alignedReq;
    end
  end

  // Trigger line register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q <= '0;
    end else begin
      base_d_check: base_q <= base_d;
    end
  end
`endif

  // Next-state logic: walk the lines of one trigger, one request at a time;
  // a flush from any state wins over everything else.
  always_comb begin
    state_d    = state_q;
    nextAddr_d = nextAddr_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    case (state_q)
      StIdle: begin
        if (popFire) begin
          nextAddr_d = alignedReq + LineStep;
          cnt_d      = CntFirst;
          state_d    = StCheck;
        end
      end
      StCheck: begin
        state_d = pageCross ? StIdle : StIssue;
      end
      StIssue: begin
        if (req_ready_i) begin
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + TimerW'(1);
        if (rsp_valid_i || timerExpired) begin
          if (cnt_q == CntLast) begin
            state_d = StIdle;
          end else begin
            cnt_d      = cnt_q + CntW'(1);
            nextAddr_d = nextAddr_q + LineStep;
            state_d    = StCheck;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (flush_i) begin
      state_d = StIdle;
    end
  end

  // State, line counter, request address and response timer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      nextAddr_q <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      nextAddr_q <= nextAddr_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
    end
  end

  // Outputs derive from the registered state; the request address reads as
  // zero whenever no request is being offered.
  assign stack_pop_o = popFire;
  assign req_valid_o = (state_q == StIssue);
  assign req_addr_o  = (state_q == StIssue) ? nextAddr_q : '0;
  assign busy_o      = (state_q != StIdle);

  // A response arriving in the last WAIT cycle still counts as a response.
  assign timeout_o   = (state_q == StWait) & timerExpired & ~rsp_valid_i;

endmodule

// File: doc/hwpf_issuer.md
Name: hwpf_issuer

Overview:
Consumer end of the hardware-prefetcher address stack. Pops the top-of-stack trigger address and converts it into NUM_LINES next-line prefetch requests toward the L1/memory port. Uses a valid/ready request handshake and a single-beat response. At most one request is outstanding at a time, bounded by a response timeout.

Parameters:
ADDR_W, 40, width of physical address (matches drac_pkg::addr_t)
LINE_BYTES, 64, cache line size in bytes; power of two
NUM_LINES, 2, next lines requested per trigger; range 1..8
PAGE_BYTES, 4096, page size used for the boundary check; power of two
TIMEOUT_CYCLES, 32, WAIT cycles before a request is abandoned; >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  abort current trigger, return to IDLE
stack_valid_i  in  1  stack top holds a valid address
stack_req_i  in  ADDR_W  stack top address
stack_pop_o  out  1  pop stack top (combinational, one cycle)
req_valid_o  out  1  prefetch request valid
req_ready_i  in  1  downstream accepts request
req_addr_o  out  ADDR_W  line-aligned prefetch address
rsp_valid_i  in  1  response for outstanding request
busy_o  out  1  FSM not in IDLE
timeout_o  out  1  one-cycle pulse when a request is abandoned

Behaviour:
- Reset (async, rst_i=1): state=IDLE, base/cnt/timer=0. All outputs 0; req_addr_o=0.
- Registers:
  - base: ADDR_W, stack address with low log2(LINE_BYTES) bits cleared.
  - cnt: 1..NUM_LINES.
  - timer: clog2(TIMEOUT_CYCLES) bits.
  - next_addr: registered base + cnt*LINE_BYTES, modulo 2^ADDR_W; wrap silently.
- IDLE:
  - stack_pop_o = stack_valid_i & ~flush_i, same cycle.
  - On pop: base <= aligned stack_req_i, cnt <= 1, next_addr <= base+LINE_BYTES, go CHECK.
- CHECK (1 cycle):
  - Page cross = next_addr[ADDR_W-1:log2(PAGE_BYTES)] != base[ADDR_W-1:log2(PAGE_BYTES)].
  - If page cross (macro off): go IDLE, no request; the remaining lines for this trigger are dropped.
  - Otherwise go ISSUE.
- ISSUE:
  - req_valid_o=1, req_addr_o=next_addr. Both held stable until req_ready_i.
  - On req_valid_o & req_ready_i: timer <= 0, go WAIT.
  - First request appears 2 cycles after the pop cycle.
- WAIT:
  - req_valid_o=0. timer increments each cycle.
  - On rsp_valid_i, or on timer==TIMEOUT_CYCLES-1 without response (timeout_o=1 that cycle):
    - If cnt==NUM_LINES: go IDLE.
    - Else cnt++, next_addr += LINE_BYTES, go CHECK.
  - Response and timeout in the same cycle count as a response; timeout_o=0.
- rsp_valid_i outside WAIT is ignored.
- flush_i in any state: next state IDLE. Clears req_valid_o next cycle; no pop in that cycle.
  - If flush_i and req_ready_i coincide in ISSUE, the request counts as sent but its response is ignored.
- No new pop until return to IDLE. The stack's own overflow policy governs triggers that arrive meanwhile.
- busy_o = (state != IDLE), registered-state derived.

Optional Feature:
HWPF_PAGE_CROSS_EN
- Defined: the CHECK-state page comparison is removed. Requests continue across page boundaries; CHECK always goes to ISSUE.
- Undefined: page-cross check as described in Behaviour; the trigger ends at the first line in a different page.

Test Plan:
- Reset/idle: rst_i=1 mid-WAIT, then release.
  - Required: busy_o=0, req_valid_o=0, stack_pop_o=0.
  - Required: no request until stack_valid_i.
- Basic trigger: NUM_LINES=2, stack_req_i=0xCAFE0001, req_ready_i=1, rsp_valid_i one cycle after each accept.
  - Required: one-cycle stack_pop_o.
  - Required: requests 0xCAFE0040 then 0xCAFE0080, then IDLE.
- Backpressure: req_ready_i=0 for 5 cycles on 0xCAFE0040.
  - Required: req_valid_o and req_addr_o held stable for 5 cycles; accepted on the 6th.
- Page boundary: stack_req_i=0xCAFE0FC0, NUM_LINES=2.
  - Macro off: zero requests, IDLE after CHECK.
  - Macro on: requests 0xCAFE1000, 0xCAFE1040.
- Timeout: never assert rsp_valid_i.
  - Required: timeout_o pulses TIMEOUT_CYCLES cycles after each accept.
  - Required: second line still issued; both lines time out; then IDLE.
- Flush: flush_i in WAIT for 0xCAFE0040.
  - Required: IDLE next cycle; no 0xCAFE0080 request.
  - Required: late rsp_valid_i ignored; next stack_valid_i popped normally.
